// File: rtl/cpu86_mem_sram_bridge.sv
// cpu86 memory-port slave that runs each 64-bit request on a single-port
// synchronous SRAM, with optional wait states, and returns read data on a
// 32-bit response stream that has no backpressure.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | ready for a request; a handshake latches the request fields
// ST_WAIT   | burning wait states; the counter counts down to zero
// ST_ACCESS | SRAM strobe cycle; with no wait states a new request may chain
module cpu86_mem_sram_bridge #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 0,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_axis_req_tvalid,
    output logic              s_axis_req_tready,
    input  logic [63:0]       s_axis_req_tdata,
    output logic              m_axis_res_tvalid,
    output logic [31:0]       m_axis_res_tdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  ready_en_q;
    logic                  hs;
    logic                  acc_start;
    logic                  use_req;

    logic                  req_wr;
    logic [3:0]            req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;

    logic                  lat_wr;
    logic [3:0]            lat_be;
    logic [ADDR_W-1:0]     lat_addr;
    logic [31:0]           lat_wdata;

    logic                  src_wr;
    logic [3:0]            src_be;
    logic [ADDR_W-1:0]     src_addr;
    logic [31:0]           src_wdata;

    logic [RD_LATENCY-1:0] rd_pend_q;
    logic                  unused_tdata;

    // Byte-address bits [1:0] and the reserved fields carry no meaning here.
    assign req_wr       = s_axis_req_tdata[63];
    assign req_be       = s_axis_req_tdata[59:56];
    assign req_addr     = s_axis_req_tdata[ADDR_W+33:34];
    assign req_wdata    = s_axis_req_tdata[31:0];
    assign unused_tdata = ^{s_axis_req_tdata[62:60], s_axis_req_tdata[55:52],
                            s_axis_req_tdata[33:32]};

    // With no wait states the access is issued straight from the bus fields,
    // otherwise from the copy latched at the handshake.
    assign src_wr    = use_req ? req_wr    : lat_wr;
    assign src_be    = use_req ? req_be    : lat_be;
    assign src_addr  = use_req ? req_addr  : lat_addr;
    assign src_wdata = use_req ? req_wdata : lat_wdata;

    // Registered ready enable keeps tready low through reset and for the release edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_en_q <= 1'b0;
        else         ready_en_q <= 1'b1;
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next-state, handshake and access-start decode.
    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        s_axis_req_tready = 1'b0;
        hs                = 1'b0;
        acc_start         = 1'b0;
        use_req           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_req_tready = ready_en_q;
                if (s_axis_req_tvalid && ready_en_q) begin
                    hs = 1'b1;
                    if (NO_WAIT) begin
                        state_d   = ST_ACCESS;
                        acc_start = 1'b1;
                        use_req   = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d   = ST_ACCESS;
                    acc_start = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (NO_WAIT) begin
                    s_axis_req_tready = ready_en_q;
                    if (s_axis_req_tvalid && ready_en_q) begin
                        hs        = 1'b1;
                        state_d   = ST_ACCESS;
                        acc_start = 1'b1;
                        use_req   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request fields on every handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_wr    <= 1'b0;
            lat_be    <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
        end else if (hs) begin
            lat_wr    <= req_wr;
            lat_be    <= req_be;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Registered SRAM port; a write with no byte lanes still sequences but never strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= 4'd0;
            ram_addr  <= '0;
            ram_wdata <= 32'd0;
        end else if (acc_start) begin
            ram_en    <= src_wr ? (src_be != 4'd0) : 1'b1;
            ram_we    <= src_wr;
            ram_be    <= src_wr ? src_be : 4'hF;
            ram_addr  <= src_addr;
            ram_wdata <= src_wdata;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
        end
    end

    // Read-pending pipe tracks when SRAM read data becomes valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pend_q <= '0;
        end else begin
            rd_pend_q[0] <= ram_en & ~ram_we;
            for (int i = 1; i < RD_LATENCY; i++) rd_pend_q[i] <= rd_pend_q[i-1];
        end
    end

    // Response register: one pulse per read, data held between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_axis_res_tvalid <= 1'b0;
            m_axis_res_tdata  <= 32'd0;
        end else begin
            m_axis_res_tvalid <= rd_pend_q[RD_LATENCY-1];
            if (rd_pend_q[RD_LATENCY-1]) m_axis_res_tdata <= ram_rdata;
        end
    end

endmodule
